// File: rtl/red_pitaya_pfd_scheduler_if.sv
// Request/result bundle between the I/Q requesters and the shared CORDIC phase engine.
// The master side is the requester array, the slave side is the scheduler.
interface red_pitaya_pfd_scheduler_if #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned CHW        = 2,
  parameter int unsigned INPUTWIDTH = 19,
  parameter int unsigned PHASEWIDTH = 10,
  parameter int unsigned TURNWIDTH  = 4
);
  logic [NCH-1:0]                      req_i;
  logic [NCH*INPUTWIDTH-1:0]           i_i;
  logic [NCH*INPUTWIDTH-1:0]           q_i;
  logic [NCH-1:0]                      clr_turns_i;
  logic [NCH-1:0]                      ack_o;
  logic                                busy_o;
  logic                                res_valid_o;
  logic [CHW-1:0]                      res_ch_o;
  logic [TURNWIDTH+PHASEWIDTH-1:0]     res_o;

  modport master (
    output req_i, i_i, q_i, clr_turns_i,
    input  ack_o, busy_o, res_valid_o, res_ch_o, res_o
  );

  modport slave (
    input  req_i, i_i, q_i, clr_turns_i,
    output ack_o, busy_o, res_valid_o, res_ch_o, res_o
  );
endinterface

// File: rtl/red_pitaya_pfd_scheduler.sv
// Round-robin scheduler sharing one iterative vectoring CORDIC between NCH I/Q channels,
// producing per-channel unwrapped {turns, phase} results.
module red_pitaya_pfd_scheduler #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CHW          = 2,
  parameter int unsigned INPUTWIDTH   = 19,
  parameter int unsigned WORKINGWIDTH = 23,
  parameter int unsigned PHASEWIDTH   = 10,
  parameter int unsigned TURNWIDTH    = 4,
  parameter int unsigned NSTAGES      = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  red_pitaya_pfd_scheduler_if.slave   bus
);

  localparam int unsigned WW   = WORKINGWIDTH;
  localparam int unsigned PadW = WORKINGWIDTH - INPUTWIDTH - 2;
  localparam int unsigned RW   = TURNWIDTH + PHASEWIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StIter, StDone} state_e;

  state_e                         state_q, state_d;
  logic [CHW-1:0]                 rr_q, rr_d, g_q, g_d;
  logic signed [WW-1:0]           wi_q, wi_d, wq_q, wq_d;
  logic [PHASEWIDTH-1:0]          ph_q, ph_d;
  logic [2:0]                     k_q, k_d;
  logic [1:0]                     qd_q, qd_d;
  logic [NCH-1:0][TURNWIDTH-1:0]  turns_q, turns_d;
  logic [NCH-1:0][1:0]            last_q, last_d;
  logic [NCH-1:0]                 ack_q, ack_d;
  logic                           res_valid_q, res_valid_d;
  logic [CHW-1:0]                 res_ch_q, res_ch_d;
  logic [RW-1:0]                  res_q, res_d;

  logic                           grant_found;
  logic [CHW-1:0]                 grant_ch, cand;
  logic [TURNWIDTH-1:0]           turn_new;
  logic signed [WW-1:0]           i_shr, q_shr;
  logic [PHASEWIDTH-1:0]          atan_k;

  // Two guard bits on top for prerotation and CORDIC gain, zero padding below.
  function automatic logic signed [WW-1:0] extend(input logic [INPUTWIDTH-1:0] x);
    logic signed [WW-1:0] t;
    t = WW'(signed'(x));
    return t <<< PadW;
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      cand = CHW'((32'(rr_q) + n) % NCH);
      if (!grant_found && bus.req_i[cand]) begin
        grant_found = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  always_comb begin
    case (k_q)
      3'd0:    atan_k = PHASEWIDTH'(75);
      3'd1:    atan_k = PHASEWIDTH'(39);
      3'd2:    atan_k = PHASEWIDTH'(20);
      3'd3:    atan_k = PHASEWIDTH'(10);
      3'd4:    atan_k = PHASEWIDTH'(5);
      3'd5:    atan_k = PHASEWIDTH'(2);
      3'd6:    atan_k = PHASEWIDTH'(1);
      default: atan_k = '0;
    endcase
  end

  assign i_shr = wi_q >>> (k_q + 3'd1);
  assign q_shr = wq_q >>> (k_q + 3'd1);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    g_d         = g_q;
    wi_d        = wi_q;
    wq_d        = wq_q;
    ph_d        = ph_q;
    k_d         = k_q;
    qd_d        = qd_q;
    turns_d     = turns_q;
    last_d      = last_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_d       = res_q;
    turn_new    = turns_q[g_q];

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          ack_d[grant_ch] = 1'b1;
          g_d     = grant_ch;
          wi_d    = extend(bus.i_i[grant_ch*INPUTWIDTH +: INPUTWIDTH]);
          wq_d    = extend(bus.q_i[grant_ch*INPUTWIDTH +: INPUTWIDTH]);
          rr_d    = (32'(grant_ch) == NCH - 1) ? '0 : grant_ch + 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Rotate into the half-plane around the q=0 axis; ph tracks the removed angle.
        qd_d = {wi_q[WW-1], wq_q[WW-1]};
        case (qd_d)
          2'b00: begin wi_d = wi_q + wq_q;  wq_d = wq_q - wi_q;  ph_d = PHASEWIDTH'(640); end
          2'b01: begin wi_d = wi_q - wq_q;  wq_d = wi_q + wq_q;  ph_d = PHASEWIDTH'(384); end
          2'b10: begin wi_d = wq_q - wi_q;  wq_d = -wi_q - wq_q; ph_d = PHASEWIDTH'(896); end
          default: begin wi_d = -wi_q - wq_q; wq_d = wi_q - wq_q; ph_d = PHASEWIDTH'(128); end
        endcase
        k_d     = '0;
        state_d = StIter;
      end
      StIter: begin
        if (wq_q[WW-1]) begin
          wi_d = wi_q - q_shr;
          wq_d = wq_q + i_shr;
          ph_d = ph_q - atan_k;
        end else begin
          wi_d = wi_q + q_shr;
          wq_d = wq_q - i_shr;
          ph_d = ph_q + atan_k;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'(NSTAGES - 1)) state_d = StDone;
      end
      StDone: begin
        if (qd_q == 2'b10 && last_q[g_q] == 2'b11) begin
          turn_new = turns_q[g_q] - TURNWIDTH'(1);
        end else if (qd_q == 2'b11 && last_q[g_q] == 2'b10) begin
          turn_new = turns_q[g_q] + TURNWIDTH'(1);
        end
        if (bus.clr_turns_i[g_q]) turn_new = '0;
        turns_d[g_q] = turn_new;
        last_d[g_q]  = qd_q;
        res_valid_d  = 1'b1;
        res_ch_d     = g_q;
        res_d        = {turn_new, ph_q};
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    for (int unsigned c = 0; c < NCH; c++) begin
      if (bus.clr_turns_i[c]) turns_d[c] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      g_q         <= '0;
      wi_q        <= '0;
      wq_q        <= '0;
      ph_q        <= '0;
      k_q         <= '0;
      qd_q        <= '0;
      turns_q     <= '0;
      last_q      <= '1;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      g_q         <= g_d;
      wi_q        <= wi_d;
      wq_q        <= wq_d;
      ph_q        <= ph_d;
      k_q         <= k_d;
      qd_q        <= qd_d;
      turns_q     <= turns_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_q       <= res_d;
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_ch_o    = res_ch_q;
  assign bus.res_o       = res_q;

endmodule

// File: tb/tb_red_pitaya_pfd_scheduler.sv
// Bench for the shared CORDIC phase scheduler: random and directed requests checked against
// an integer reference of the phase/turn rules and against nominal atan2 phases.
module tb_red_pitaya_pfd_scheduler;
  localparam int NCH = 4, CHW = 2, IW = 19, WW = 23, PW = 10, TW = 4, NST = 7;
  localparam int ATAN [7] = '{75, 39, 20, 10, 5, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  red_pitaya_pfd_scheduler_if #(.NCH(NCH), .CHW(CHW), .INPUTWIDTH(IW), .PHASEWIDTH(PW),
                                .TURNWIDTH(TW)) bus ();

  red_pitaya_pfd_scheduler #(.NCH(NCH), .CHW(CHW), .INPUTWIDTH(IW), .WORKINGWIDTH(WW),
                             .PHASEWIDTH(PW), .TURNWIDTH(TW), .NSTAGES(NST))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int m_turns [NCH];
  logic [1:0] m_last [NCH];
  int m_rr;

  logic [NCH-1:0]   t_ack;
  int               t_lat;
  logic [CHW-1:0]   t_ch;
  logic [TW+PW-1:0] t_res, t_exp;
  logic             t_rv;
  bit               t_to;

  function automatic int rnd_in();
    return int'($urandom_range(0, 524287)) - 262144;
  endfunction

  // Vectoring CORDIC computed straight from the rotation rules on wide integers.
  function automatic int ref_phase(input int i, input int q);
    longint x, y, xn, yn;
    int ph;
    x = longint'(i) * 4;
    y = longint'(q) * 4;
    if (i >= 0 && q >= 0)  begin xn = x + y;  yn = y - x;  ph = 640; end
    else if (i >= 0)       begin xn = x - y;  yn = x + y;  ph = 384; end
    else if (q >= 0)       begin xn = y - x;  yn = -x - y; ph = 896; end
    else                   begin xn = -x - y; yn = x - y;  ph = 128; end
    x = xn; y = yn;
    for (int k = 0; k < NST; k++) begin
      if (y < 0) begin xn = x - (y >>> (k + 1)); yn = y + (x >>> (k + 1)); ph -= ATAN[k]; end
      else       begin xn = x + (y >>> (k + 1)); yn = y - (x >>> (k + 1)); ph += ATAN[k]; end
      x = xn; y = yn;
    end
    return ph & 1023;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin m_turns[c] = 0; m_last[c] = 2'b11; end
    m_rr = 0;
  endtask

  task automatic model_done(input int ch, input int i, input int q, input bit clr,
                            output logic [TW+PW-1:0] exp);
    logic [1:0] qd;
    qd = {i < 0, q < 0};
    if (qd == 2'b10 && m_last[ch] == 2'b11)      m_turns[ch] = (m_turns[ch] - 1) & 15;
    else if (qd == 2'b11 && m_last[ch] == 2'b10) m_turns[ch] = (m_turns[ch] + 1) & 15;
    if (clr) m_turns[ch] = 0;
    m_last[ch] = qd;
    exp = {TW'(m_turns[ch]), PW'(ref_phase(i, q))};
  endtask

  task automatic drive_iq(input int ch, input int i, input int q);
    bus.i_i[ch*IW +: IW] = IW'(i);
    bus.q_i[ch*IW +: IW] = IW'(q);
  endtask

  // Single-requester transaction; only collects observations, callers compare.
  task automatic do_txn(input int ch, input int i, input int q, input bit clr_done,
                        output logic [NCH-1:0] ack_seen, output int lat,
                        output logic [CHW-1:0] rch, output logic [TW+PW-1:0] res,
                        output logic rv_after, output bit to);
    int n;
    ack_seen = '0; lat = 0; rch = '0; res = '0; rv_after = 1'b1; to = 1'b1;
    drive_iq(ch, i, q);
    bus.req_i = '0;
    bus.req_i[ch] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.ack_o === '0 && n < 40);
    ack_seen = bus.ack_o;
    bus.req_i = '0;
    if (ack_seen === '0) return;
    drive_iq(ch, rnd_in(), rnd_in());
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (clr_done) bus.clr_turns_i[ch] = (n == 8);
    end while (bus.res_valid_o !== 1'b1 && n < 40);
    bus.clr_turns_i = '0;
    if (bus.res_valid_o !== 1'b1) return;
    lat = n; rch = bus.res_ch_o; res = bus.res_o; to = 1'b0;
    @(posedge clk); #1;
    rv_after = bus.res_valid_o;
  endtask

  task automatic test_reset();
    bus.req_i = '0; bus.i_i = '0; bus.q_i = '0; bus.clr_turns_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ack_o !== '0) begin failures++; $display("FAIL reset_ack: got %b want 0", bus.ack_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.res_valid_o); end
    checks++; if (bus.res_ch_o !== '0) begin failures++; $display("FAIL reset_ch: got %0d want 0", bus.res_ch_o); end
    checks++; if (bus.res_o !== '0) begin failures++; $display("FAIL reset_res: got %h want 0", bus.res_o); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_phase();
    int chs [4] = '{0, 1, 1, 1};
    int is  [4] = '{100000, 0, -100000, 0};
    int qs  [4] = '{0, 100000, 0, -100000};
    int nom [4] = '{512, 768, 0, 256};
    logic [NCH-1:0] ea;
    int d;
    for (int n = 0; n < 4; n++) begin
      do_txn(chs[n], is[n], qs[n], 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
      model_done(chs[n], is[n], qs[n], 1'b0, t_exp);
      ea = '0; ea[chs[n]] = 1'b1;
      d = (int'(t_res[PW-1:0]) - nom[n] + 1536) % 1024 - 512;
      checks++; if (t_ack !== ea) begin failures++; $display("FAIL phase_ack[%0d]: got %b want %b", n, t_ack, ea); end
      checks++; if (t_lat !== 9) begin failures++; $display("FAIL phase_latency[%0d]: got %0d want 9", n, t_lat); end
      checks++; if (t_ch !== CHW'(chs[n])) begin failures++; $display("FAIL phase_ch[%0d]: got %0d want %0d", n, t_ch, chs[n]); end
      checks++; if (t_res !== t_exp) begin failures++; $display("FAIL phase_res[%0d]: got %h want %h", n, t_res, t_exp); end
      checks++; if (d < -2 || d > 2) begin failures++; $display("FAIL phase_nominal[%0d]: got %0d want %0d+-2", n, t_res[PW-1:0], nom[n]); end
      checks++; if (t_res[TW+PW-1:PW] !== 4'h0) begin failures++; $display("FAIL phase_turns[%0d]: got %h want 0", n, t_res[TW+PW-1:PW]); end
      checks++; if (t_rv !== 1'b0) begin failures++; $display("FAIL phase_pulse[%0d]: got %b want 0", n, t_rv); end
    end
  endtask

  task automatic test_turns();
    int ti [$];
    int tq [$];
    ti = '{-100000, -100000, -100000, -100000};
    tq = '{-1, 1, 1, -1};
    for (int k = 0; k < 16; k++) begin
      ti.push_back(-100000); tq.push_back(1);
      ti.push_back(100000);  tq.push_back(1);
      ti.push_back(100000);  tq.push_back(-1);
      ti.push_back(-100000); tq.push_back(-1);
    end
    for (int n = 0; n < ti.size(); n++) begin
      do_txn(2, ti[n], tq[n], 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
      model_done(2, ti[n], tq[n], 1'b0, t_exp);
      checks++; if (t_res !== t_exp || t_lat !== 9) begin
        failures++; $display("FAIL turns_res[%0d]: got %h lat %0d want %h lat 9", n, t_res, t_lat, t_exp); end
      if (n == 1 || n == 2) begin
        checks++; if (t_res[TW+PW-1:PW] !== 4'hF) begin failures++; $display("FAIL turns_minus1[%0d]: got %h want f", n, t_res[TW+PW-1:PW]); end
      end
      if (n == 3 || n == ti.size() - 1) begin
        checks++; if (t_res[TW+PW-1:PW] !== 4'h0) begin failures++; $display("FAIL turns_zero[%0d]: got %h want 0", n, t_res[TW+PW-1:PW]); end
      end
    end
  endtask

  task automatic test_round_robin();
    int ri [NCH];
    int rq [NCH];
    int last_ack, nacks, pend;
    logic [NCH-1:0] ea;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++) begin ri[c] = rnd_in(); rq[c] = rnd_in(); drive_iq(c, ri[c], rq[c]); end
    bus.req_i = '1;
    last_ack = -1; nacks = 0; pend = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      if (bus.ack_o !== '0) begin
        ea = '0; ea[m_rr] = 1'b1;
        checks++; if (bus.ack_o !== ea) begin failures++; $display("FAIL rr_order[%0d]: got %b want %b", nacks, bus.ack_o, ea); end
        if (last_ack >= 0) begin
          checks++; if (cyc - last_ack !== 10) begin failures++; $display("FAIL rr_spacing[%0d]: got %0d want 10", nacks, cyc - last_ack); end
        end
        last_ack = cyc; pend = m_rr; m_rr = (m_rr + 1) % NCH; nacks++;
      end
      if (bus.res_valid_o === 1'b1) begin
        model_done(pend, ri[pend], rq[pend], 1'b0, t_exp);
        checks++; if (bus.res_ch_o !== CHW'(pend)) begin failures++; $display("FAIL rr_ch: got %0d want %0d", bus.res_ch_o, pend); end
        checks++; if (bus.res_o !== t_exp) begin failures++; $display("FAIL rr_res: got %h want %h", bus.res_o, t_exp); end
      end
      if (cyc == 45) bus.req_i = '0;
    end
    checks++; if (nacks < 5) begin failures++; $display("FAIL rr_count: got %0d want >=5", nacks); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rr_idle: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    do_txn(1, -100000, -1, 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
    model_done(1, -100000, -1, 1'b0, t_exp);
    do_txn(1, -100000, 1, 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
    model_done(1, -100000, 1, 1'b0, t_exp);
    checks++; if (t_res !== t_exp) begin failures++; $display("FAIL rmid_pre: got %h want %h", t_res, t_exp); end
    drive_iq(3, 50000, 70000);
    bus.req_i = 4'b1000;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.ack_o === '0 && n < 40);
    bus.req_i = '0;
    checks++; if (bus.ack_o !== 4'b1000) begin failures++; $display("FAIL rmid_ack: got %b want 1000", bus.ack_o); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.res_o !== '0 || bus.res_ch_o !== '0) begin
      failures++; $display("FAIL rmid_outputs: got %h/%0d want 0/0", bus.res_o, bus.res_ch_o); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (bus.res_valid_o === 1'b1) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmid_dropped: got %0d results want 0", seen); end
    for (int c = 0; c < NCH; c++) drive_iq(c, 100000, 0);
    bus.req_i = '1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.ack_o === '0 && n < 40);
    bus.req_i = '0;
    checks++; if (bus.ack_o !== 4'b0001) begin failures++; $display("FAIL rmid_first_grant: got %b want 0001", bus.ack_o); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.res_valid_o !== 1'b1 && n < 40);
    model_done(0, 100000, 0, 1'b0, t_exp);
    checks++; if (bus.res_o !== t_exp || bus.res_o[TW+PW-1:PW] !== 4'h0) begin
      failures++; $display("FAIL rmid_turns0: got %h want %h", bus.res_o, t_exp); end
    @(posedge clk); #1;
    for (int c = 1; c < NCH; c++) begin
      do_txn(c, 100000, 0, 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
      model_done(c, 100000, 0, 1'b0, t_exp);
      checks++; if (t_res !== t_exp || t_res[TW+PW-1:PW] !== 4'h0) begin
        failures++; $display("FAIL rmid_turns[%0d]: got %h want %h", c, t_res, t_exp); end
    end
  endtask

  task automatic test_clr();
    int ci [4] = '{-100000, -100000, 100000, 100000};
    int cq [4] = '{-1, 1, 1, -1};
    for (int l = 0; l < 3; l++) begin
      for (int s = 0; s < 4; s++) begin
        do_txn(2, ci[s], cq[s], 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
        model_done(2, ci[s], cq[s], 1'b0, t_exp);
        checks++; if (t_res !== t_exp) begin failures++; $display("FAIL clr_setup[%0d]: got %h want %h", l*4+s, t_res, t_exp); end
      end
    end
    checks++; if (t_res[TW+PW-1:PW] !== 4'hD) begin failures++; $display("FAIL clr_minus3: got %h want d", t_res[TW+PW-1:PW]); end
    do_txn(2, -100000, -1, 1'b1, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
    model_done(2, -100000, -1, 1'b1, t_exp);
    checks++; if (t_res !== t_exp || t_res[TW+PW-1:PW] !== 4'h0) begin
      failures++; $display("FAIL clr_wins: got %h want %h", t_res, t_exp); end
    do_txn(2, -100000, 1, 1'b0, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
    model_done(2, -100000, 1, 1'b0, t_exp);
    checks++; if (t_res !== t_exp || t_res[TW+PW-1:PW] !== 4'hF) begin
      failures++; $display("FAIL clr_recount: got %h want %h", t_res, t_exp); end
  endtask

  task automatic test_random();
    int ch, i, q;
    bit clr;
    logic [NCH-1:0] ea;
    for (int n = 0; n < 40; n++) begin
      ch = int'($urandom_range(0, NCH - 1));
      i = rnd_in(); q = rnd_in();
      clr = ($urandom_range(0, 7) == 0);
      do_txn(ch, i, q, clr, t_ack, t_lat, t_ch, t_res, t_rv, t_to);
      model_done(ch, i, q, clr, t_exp);
      ea = '0; ea[ch] = 1'b1;
      checks++; if (t_ack !== ea || t_lat !== 9) begin
        failures++; $display("FAIL rand_ack[%0d]: got %b lat %0d want %b lat 9", n, t_ack, t_lat, ea); end
      checks++; if (t_ch !== CHW'(ch) || t_res !== t_exp) begin
        failures++; $display("FAIL rand_res[%0d]: got ch%0d %h want ch%0d %h", n, t_ch, t_res, ch, t_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_phase();
    test_turns();
    test_round_robin();
    test_reset_mid();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
